ccc_lock_clken_gen: RTL and testbench

Parametrised successor to the single-CCC lock/global-clock wrapper. It runs on one fabric global clock and watches the CCC PLL LOCK output. Once lock has been stable for a set time, it produces NUM_CH aligned clock-enable strobes, each with a run-time programmable divide ratio. It also reports lock loss with a sticky flag and a saturating counter, so downstream logic uses clock enables instead of extra CCC outputs.

---
 rtl/ccc_lock_clken_gen_pkg.sv | 16 +
 rtl/ccc_lock_clken_gen_if.sv | 30 +++
 rtl/ccc_clken_channel.sv | 42 ++++
 rtl/ccc_lock_clken_gen.sv | 109 ++++++++++
 tb/tb_ccc_lock_clken_gen.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/ccc_lock_clken_gen_pkg.sv
// rtl/ccc_lock_clken_gen_pkg.sv - shared types and sizing helpers for the CCC lock clock-enable generator
package ccc_clken_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int LOSS_W = 8;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/ccc_lock_clken_gen_if.sv
// rtl/ccc_lock_clken_gen_if.sv - control/status bundle between a host and the clock-enable generator
interface ccc_lock_clken_gen_if
    import ccc_clken_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 8
);
    localparam int CH_W = ch_w(NUM_CH);

    logic                pll_lock;
    logic                div_load;
    logic [CH_W-1:0]     div_ch;
    logic [DIV_W-1:0]    div_val;
    logic                clr_loss;
    logic [NUM_CH-1:0]   en;
    logic                ready;
    logic                lock_lost;
    logic [LOSS_W-1:0]   loss_count;

    modport master (
        output pll_lock, div_load, div_ch, div_val, clr_loss,
        input  en, ready, lock_lost, loss_count
    );

    modport slave (
        input  pll_lock, div_load, div_ch, div_val, clr_loss,
        output en, ready, lock_lost, loss_count
    );

endinterface

// File: rtl/ccc_clken_channel.sv
// rtl/ccc_clken_channel.sv - one divided clock-enable channel with shadowed, wrap-synchronous divide update
module ccc_clken_channel #(
    parameter int          DIV_W   = 8,
    parameter int unsigned RST_DIV = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             ready_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_val_i,
    output logic             en_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] shadow_q;
    logic             wrap;

    assign wrap = (cnt_q == div_q);
    assign en_o = ready_i && wrap;

    // Active divide only changes while idle or at a period boundary, so no runt/stretched period.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            div_q    <= DIV_W'(RST_DIV);
            shadow_q <= DIV_W'(RST_DIV);
        end else begin
            if (load_i) begin
                shadow_q <= div_val_i;
            end
            if (!run_i || wrap) begin
                cnt_q <= '0;
                div_q <= shadow_q;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccc_lock_clken_gen.sv
// rtl/ccc_lock_clken_gen.sv - PLL lock qualifier producing aligned divided clock enables and loss statistics
module ccc_lock_clken_gen
    import ccc_clken_pkg::*;
#(
    parameter int          NUM_CH             = 3,
    parameter int          DIV_W              = 8,
    parameter int          LOCK_STABLE_CYCLES = 16,
    parameter int unsigned RST_DIV            = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ccc_lock_clken_gen_if.slave  bus
);

    localparam int                CH_W     = ch_w(NUM_CH);
    localparam int                STB_W    = $clog2(LOCK_STABLE_CYCLES);
    // The WAIT_LOCK->STABLE edge already consumes the first locked cycle.
    localparam logic [STB_W-1:0]  STB_TERM = STB_W'(LOCK_STABLE_CYCLES - 2);
    localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

    logic              lock_m_q;
    logic              lock_s_q;
    state_e            state_q;
    logic [STB_W-1:0]  stb_cnt_q;
    logic              ready_q;
    logic              lock_lost_q;
    logic [LOSS_W-1:0] loss_cnt_q;
    logic              run;
    logic [NUM_CH-1:0] en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_m_q    <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= WAIT_LOCK;
            stb_cnt_q   <= '0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            lock_m_q <= bus.pll_lock;
            lock_s_q <= lock_m_q;
            if (bus.clr_loss) begin
                lock_lost_q <= 1'b0;
                loss_cnt_q  <= '0;
            end
            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_q   <= STABLE;
                        stb_cnt_q <= '0;
                    end
                end
                STABLE: begin
                    if (!lock_s_q) begin
                        state_q   <= WAIT_LOCK;
                        stb_cnt_q <= '0;
                    end else if (stb_cnt_q == STB_TERM) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        stb_cnt_q <= stb_cnt_q + STB_W'(1);
                    end
                end
                RUN: begin
                    // A loss coinciding with a clear still records itself.
                    if (!lock_s_q) begin
                        state_q     <= WAIT_LOCK;
                        ready_q     <= 1'b0;
                        lock_lost_q <= 1'b1;
                        if (bus.clr_loss) begin
                            loss_cnt_q <= LOSS_W'(1);
                        end else if (loss_cnt_q != LOSS_MAX) begin
                            loss_cnt_q <= loss_cnt_q + LOSS_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Counters advance only while RUN persists; they zero on the edge that leaves RUN.
    assign run = ready_q && lock_s_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ccc_clken_channel #(
            .DIV_W   (DIV_W),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .run_i     (run),
            .ready_i   (ready_q),
            .load_i    (bus.div_load && (bus.div_ch == CH_W'(g))),
            .div_val_i (bus.div_val),
            .en_o      (en[g])
        );
    end

    assign bus.en         = en;
    assign bus.ready      = ready_q;
    assign bus.lock_lost  = lock_lost_q;
    assign bus.loss_count = loss_cnt_q;

endmodule

// File: tb/tb_ccc_lock_clken_gen.sv
// tb/tb_ccc_lock_clken_gen.sv - directed self-checking bench for ccc_lock_clken_gen
module tb_ccc_lock_clken_gen;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ccc_lock_clken_gen_if #(.NUM_CH(3), .DIV_W(8)) bus ();

    ccc_lock_clken_gen #(
        .NUM_CH             (3),
        .DIV_W              (8),
        .LOCK_STABLE_CYCLES (16),
        .RST_DIV            (0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drop_lock();
        bus.pll_lock = 1'b0;
        cyc(3);
        chk("drop_ready", {31'd0, bus.ready}, 32'd0);
    endtask

    task automatic relock();
        int n;
        n = 0;
        bus.pll_lock = 1'b1;
        while (!bus.ready && n < 40) begin
            cyc(1);
            n++;
        end
        chk("relock_ready", {31'd0, bus.ready}, 32'd1);
    endtask

    initial begin
        logic [2:0] e;
        rst          = 1'b1;
        bus.pll_lock = 1'b0;
        bus.div_load = 1'b0;
        bus.div_ch   = '0;
        bus.div_val  = '0;
        bus.clr_loss = 1'b0;
        cyc(2);
        chk("reset_state", {bus.en, bus.ready, bus.lock_lost, bus.loss_count}, 32'd0);
        rst = 1'b0;

        // Idle with no lock
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            chk("t1_idle", {bus.en, bus.ready, bus.lock_lost, bus.loss_count}, 32'd0);
        end

        bus.div_load = 1'b1; bus.div_ch = 2'd1; bus.div_val = 8'd1;
        cyc(1);
        bus.div_ch = 2'd2; bus.div_val = 8'd3;
        cyc(1);
        bus.div_load = 1'b0;

        // Exact lock latency and aligned enables
        bus.pll_lock = 1'b1;
        for (int j = 0; j <= 16; j++) begin
            cyc(1);
            chk("t2_ready_low", {31'd0, bus.ready}, 32'd0);
        end
        cyc(1);
        chk("t2_ready_rise", {31'd0, bus.ready}, 32'd1);
        for (int n = 1; n <= 12; n++) begin
            e = {(n % 4) == 0, (n % 2) == 0, 1'b1};
            chk("t2_en", {29'd0, bus.en}, {29'd0, e});
            cyc(1);
        end

        bus.pll_lock = 1'b0;
        cyc(2);
        chk("drop_ready_hold", {31'd0, bus.ready}, 32'd1);
        cyc(1);
        chk("drop_state", {bus.en, bus.ready, bus.lock_lost, bus.loss_count}, {3'b000, 1'b0, 1'b1, 8'd1});
        bus.clr_loss = 1'b1;
        cyc(1);
        bus.clr_loss = 1'b0;
        chk("clr_loss", {bus.lock_lost, bus.loss_count}, 32'd0);

        // Glitch during STABLE restarts qualification without a loss event
        bus.pll_lock = 1'b1;
        cyc(5);
        bus.pll_lock = 1'b0;
        cyc(3);
        bus.pll_lock = 1'b1;
        for (int j = 0; j <= 16; j++) begin
            cyc(1);
            chk("t3_ready_low", {31'd0, bus.ready}, 32'd0);
        end
        cyc(1);
        chk("t3_ready_rise", {31'd0, bus.ready}, 32'd1);
        chk("t3_no_loss", {bus.lock_lost, bus.loss_count}, 32'd0);

        // Divide change in RUN waits for the wrap
        for (int n = 1; n <= 17; n++) begin
            chk("t4_en2", {31'd0, bus.en[2]}, {31'd0, (n == 4) || (n == 10) || (n == 16)});
            chk("t4_en1", {31'd0, bus.en[1]}, {31'd0, (n % 2) == 0});
            if (n == 2) begin
                bus.div_load = 1'b1; bus.div_ch = 2'd2; bus.div_val = 8'd5;
            end
            if (n == 3) bus.div_load = 1'b0;
            cyc(1);
        end

        // Loss counter saturation
        for (int i = 1; i <= 256; i++) begin
            drop_lock();
            chk("t5_loss_count", {24'd0, bus.loss_count}, (i > 255) ? 32'd255 : i);
            relock();
        end
        chk("t5_lock_lost", {31'd0, bus.lock_lost}, 32'd1);

        bus.pll_lock = 1'b0;
        cyc(2);
        bus.clr_loss = 1'b1;
        cyc(1);
        bus.clr_loss = 1'b0;
        chk("t5_clr_coincident", {bus.ready, bus.lock_lost, bus.loss_count}, {1'b0, 1'b1, 8'd1});

        // Async reset mid-RUN, then ignored and back-to-back loads
        relock();
        cyc(3);
        #2;
        rst = 1'b1;
        bus.pll_lock = 1'b0;
        #1;
        chk("t6_async_reset", {bus.en, bus.ready, bus.lock_lost, bus.loss_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.div_load = 1'b1; bus.div_ch = 2'd3; bus.div_val = 8'd7;
        cyc(1);
        bus.div_ch = 2'd0; bus.div_val = 8'd5;
        cyc(1);
        bus.div_val = 8'd1;
        cyc(1);
        bus.div_load = 1'b0;
        chk("t6_idle_en", {29'd0, bus.en}, 32'd0);
        relock();
        for (int n = 1; n <= 8; n++) begin
            e = {1'b1, 1'b1, (n % 2) == 0};
            chk("t6_en", {29'd0, bus.en}, {29'd0, e});
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
